// File: rtl/pcie_pkg.sv
// Shared PCIe ingress definitions: controller state encoding and default word width.
package pcie_pkg;

    localparam int DATA_W_DEFAULT = 6;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_INIT   = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

endpackage

// File: rtl/pcie_ingress_fifo.sv
// Ingress word buffer: DEPTH x DATA_W register file with wrapping pointers and an occupancy count.
module pcie_ingress_fifo
    import pcie_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcie_ingress_ctrl.sv
// Host-to-PCIe ingress flow controller with stall detection.
// Optional launched-word counter output enabled by defining PCIE_INGRESS_STATS_EN.
module pcie_ingress_ctrl
    import pcie_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              Pausa_MF,
    output logic [DATA_W-1:0] data_in_principal,
    output logic              push,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out
`ifdef PCIE_INGRESS_STATS_EN
    ,
    output logic [15:0]       words_sent
`endif
);

    localparam int SW = $clog2(STALL_MAX + 1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [SW-1:0]     stall_cnt;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              launch;
    logic              stalled;
    logic              stall_hit;

    assign host_ready = reset_L && ((state == ST_IDLE) || (state == ST_ACTIVE)) && !full;

    // A pending init takes priority over both the host write and the launch.
    assign wr_en     = host_valid && host_ready && !init;
    assign launch    = (state == ST_ACTIVE) && !empty && !Pausa_MF && !init;
    assign stalled   = host_valid && full;
    assign stall_hit = stalled && (stall_cnt == SW'(STALL_MAX - 1));

    assign idle_out   = (state == ST_IDLE);
    assign active_out = (state == ST_ACTIVE);
    assign error_out  = (state == ST_ERROR);

    pcie_ingress_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .clr     (state == ST_INIT),
        .wr_en   (wr_en),
        .wr_data (host_data),
        .rd_en   (launch),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_next = state;
        if (init) begin
            state_next = ST_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stall_hit)  state_next = ST_ERROR;
                    else if (wr_en) state_next = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (stall_hit)            state_next = ST_ERROR;
                    else if (empty && !wr_en) state_next = ST_IDLE;
                end
                ST_INIT:  state_next = ST_IDLE;
                default:  state_next = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stall counter saturates so a host still pushing in ERROR cannot wrap it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stall_cnt <= '0;
        end else if (state == ST_INIT || !stalled) begin
            stall_cnt <= '0;
        end else if (stall_cnt != SW'(STALL_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push              <= 1'b0;
            data_in_principal <= '0;
        end else begin
            push <= launch;
            if (launch) begin
                data_in_principal <= head;
            end
        end
    end

`ifdef PCIE_INGRESS_STATS_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            words_sent <= '0;
        end else if (state == ST_INIT) begin
            words_sent <= '0;
        end else if (launch) begin
            words_sent <= words_sent + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_ingress_ctrl.sv
// Directed self-checking bench for pcie_ingress_ctrl (stats port checked when PCIE_INGRESS_STATS_EN is defined).
module tb_pcie_ingress_ctrl;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [5:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic       Pausa_MF;
    logic [5:0] data_in_principal;
    logic       push;
    logic       idle_out;
    logic       active_out;
    logic       error_out;
`ifdef PCIE_INGRESS_STATS_EN
    logic [15:0] words_sent;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    pcie_ingress_ctrl #(
        .DATA_W    (6),
        .DEPTH     (4),
        .STALL_MAX (8)
    ) dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .init              (init),
        .host_data         (host_data),
        .host_valid        (host_valid),
        .host_ready        (host_ready),
        .Pausa_MF          (Pausa_MF),
        .data_in_principal (data_in_principal),
        .push              (push),
        .idle_out          (idle_out),
        .active_out        (active_out),
        .error_out         (error_out)
`ifdef PCIE_INGRESS_STATS_EN
        ,
        .words_sent        (words_sent)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_L = 1'b0; init = 1'b0; host_data = '0; host_valid = 1'b0; Pausa_MF = 1'b0;
        #2;
        total_cnt++; if (push !== 1'b0) $display("FAIL reset_push got=%0b exp=0", push); else pass_cnt++;
        total_cnt++; if (data_in_principal !== 6'h00) $display("FAIL reset_data got=%h exp=00", data_in_principal); else pass_cnt++;
        total_cnt++; if (idle_out !== 1'b1) $display("FAIL reset_idle got=%0b exp=1", idle_out); else pass_cnt++;
        total_cnt++; if (active_out !== 1'b0 || error_out !== 1'b0) $display("FAIL reset_active_error got=%0b%0b exp=00", active_out, error_out); else pass_cnt++;
        total_cnt++; if (host_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", host_ready); else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        reset_L = 1'b1;
        #1;
        total_cnt++; if (host_ready !== 1'b1) $display("FAIL release_ready got=%0b exp=1", host_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [5:0] words [0:2];
        words[0] = 6'h15; words[1] = 6'h2A; words[2] = 6'h3F;
        host_valid = 1'b1; host_data = words[0];
        step;
        total_cnt++; if (active_out !== 1'b1 || push !== 1'b0) $display("FAIL b2b_first_accept active=%0b push=%0b exp active=1 push=0", active_out, push); else pass_cnt++;
        total_cnt++; if (dut.u_fifo.count !== 3'd1) $display("FAIL b2b_count got=%0d exp=1", dut.u_fifo.count); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) host_data = words[i+1];
            else host_valid = 1'b0;
            step;
            total_cnt++;
            if (push !== 1'b1 || data_in_principal !== words[i])
                $display("FAIL b2b_launch%0d push=%0b data=%h exp push=1 data=%h", i, push, data_in_principal, words[i]);
            else pass_cnt++;
        end
        step;
        total_cnt++; if (push !== 1'b0 || idle_out !== 1'b1) $display("FAIL b2b_to_idle push=%0b idle=%0b exp push=0 idle=1", push, idle_out); else pass_cnt++;
        total_cnt++; if (data_in_principal !== 6'h3F) $display("FAIL b2b_data_hold got=%h exp=3f", data_in_principal); else pass_cnt++;
    endtask

    task automatic test_pause;
        Pausa_MF = 1'b1; host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_data = 6'(i + 1);
            step;
            total_cnt++; if (push !== 1'b0) $display("FAIL pause_no_push%0d got=%0b exp=0", i, push); else pass_cnt++;
        end
        total_cnt++; if (host_ready !== 1'b0) $display("FAIL pause_full_ready got=%0b exp=0", host_ready); else pass_cnt++;
        host_valid = 1'b0; Pausa_MF = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            total_cnt++;
            if (push !== 1'b1 || data_in_principal !== 6'(i + 1))
                $display("FAIL pause_release%0d push=%0b data=%h exp push=1 data=%h", i, push, data_in_principal, 6'(i + 1));
            else pass_cnt++;
        end
        step;
        total_cnt++; if (push !== 1'b0 || idle_out !== 1'b1) $display("FAIL pause_drained push=%0b idle=%0b exp push=0 idle=1", push, idle_out); else pass_cnt++;
    endtask

    task automatic test_stall_error;
        Pausa_MF = 1'b1; host_valid = 1'b1; host_data = 6'h0A;
        for (int i = 0; i < 4; i++) step;
        for (int i = 0; i < 7; i++) step;
        total_cnt++; if (error_out !== 1'b0) $display("FAIL stall_early_error got=%0b exp=0", error_out); else pass_cnt++;
        step;
        total_cnt++; if (error_out !== 1'b1 || host_ready !== 1'b0) $display("FAIL stall_error error=%0b ready=%0b exp error=1 ready=0", error_out, host_ready); else pass_cnt++;
        host_valid = 1'b0; Pausa_MF = 1'b0;
        step;
        total_cnt++; if (push !== 1'b0 || error_out !== 1'b1) $display("FAIL error_sticky push=%0b error=%0b exp push=0 error=1", push, error_out); else pass_cnt++;
        total_cnt++; if (dut.u_fifo.count !== 3'd4) $display("FAIL error_hold_count got=%0d exp=4", dut.u_fifo.count); else pass_cnt++;
        init = 1'b1;
        step;
        total_cnt++; if (error_out !== 1'b0 || idle_out !== 1'b0 || active_out !== 1'b0) $display("FAIL init_state err=%0b idle=%0b act=%0b exp 000", error_out, idle_out, active_out); else pass_cnt++;
        init = 1'b0;
        step;
        total_cnt++; if (idle_out !== 1'b1 || dut.u_fifo.count !== 3'd0) $display("FAIL init_exit idle=%0b count=%0d exp idle=1 count=0", idle_out, dut.u_fifo.count); else pass_cnt++;
    endtask

    task automatic test_init_collision;
        init = 1'b1; host_valid = 1'b1; host_data = 6'h3F;
        step;
        total_cnt++; if (dut.u_fifo.count !== 3'd0 || idle_out !== 1'b0) $display("FAIL init_wins count=%0d idle=%0b exp count=0 idle=0", dut.u_fifo.count, idle_out); else pass_cnt++;
        init = 1'b0; host_valid = 1'b0;
        step;
        total_cnt++; if (idle_out !== 1'b1 || dut.u_fifo.count !== 3'd0) $display("FAIL init_collision_exit idle=%0b count=%0d exp idle=1 count=0", idle_out, dut.u_fifo.count); else pass_cnt++;
    endtask

    task automatic test_wrap;
        logic [5:0] expect_q [0:7];
        expect_q[0] = 6'h11; expect_q[1] = 6'h22;
        expect_q[2] = 6'h15; expect_q[3] = 6'h2A; expect_q[4] = 6'h15;
        expect_q[5] = 6'h2A; expect_q[6] = 6'h15; expect_q[7] = 6'h2A;
        Pausa_MF = 1'b1; host_valid = 1'b1;
        host_data = 6'h11; step;
        host_data = 6'h22; step;
        total_cnt++; if (dut.u_fifo.count !== 3'd2) $display("FAIL wrap_prefill got=%0d exp=2", dut.u_fifo.count); else pass_cnt++;
        Pausa_MF = 1'b0;
        for (int i = 0; i < 6; i++) begin
            host_data = (i % 2 == 0) ? 6'h15 : 6'h2A;
            step;
            total_cnt++;
            if (push !== 1'b1 || data_in_principal !== expect_q[i] || dut.u_fifo.count !== 3'd2)
                $display("FAIL wrap_cycle%0d push=%0b data=%h count=%0d exp push=1 data=%h count=2", i, push, data_in_principal, dut.u_fifo.count, expect_q[i]);
            else pass_cnt++;
        end
        host_valid = 1'b0;
        for (int i = 6; i < 8; i++) begin
            step;
            total_cnt++;
            if (push !== 1'b1 || data_in_principal !== expect_q[i])
                $display("FAIL wrap_drain%0d push=%0b data=%h exp push=1 data=%h", i, push, data_in_principal, expect_q[i]);
            else pass_cnt++;
        end
        step; step;
        total_cnt++; if (idle_out !== 1'b1 || push !== 1'b0) $display("FAIL wrap_idle idle=%0b push=%0b exp idle=1 push=0", idle_out, push); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        Pausa_MF = 1'b0; host_valid = 1'b1;
        host_data = 6'h07; step;
        host_data = 6'h08; step;
        total_cnt++; if (push !== 1'b1 || data_in_principal !== 6'h07) $display("FAIL mid_pre push=%0b data=%h exp push=1 data=07", push, data_in_principal); else pass_cnt++;
        #2;
        reset_L = 1'b0;
        #1;
        total_cnt++; if (push !== 1'b0 || data_in_principal !== 6'h00) $display("FAIL mid_reset_out push=%0b data=%h exp push=0 data=00", push, data_in_principal); else pass_cnt++;
        total_cnt++; if (host_ready !== 1'b0 || idle_out !== 1'b1) $display("FAIL mid_reset_status ready=%0b idle=%0b exp ready=0 idle=1", host_ready, idle_out); else pass_cnt++;
        host_valid = 1'b0;
        @(posedge clk); #1;
        reset_L = 1'b1;
        step;
        total_cnt++; if (dut.u_fifo.count !== 3'd0 || idle_out !== 1'b1 || push !== 1'b0) $display("FAIL mid_release count=%0d idle=%0b push=%0b exp 0/1/0", dut.u_fifo.count, idle_out, push); else pass_cnt++;
    endtask

`ifdef PCIE_INGRESS_STATS_EN
    task automatic test_stats;
        Pausa_MF = 1'b0; host_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_data = 6'(i + 1);
            step;
        end
        host_valid = 1'b0;
        step; step; step;
        total_cnt++; if (words_sent !== 16'd5) $display("FAIL stats_count got=%0d exp=5", words_sent); else pass_cnt++;
        init = 1'b1; step;
        init = 1'b0; step;
        total_cnt++; if (words_sent !== 16'd0) $display("FAIL stats_init got=%0d exp=0", words_sent); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset;
        test_back_to_back;
        test_pause;
        test_stall_error;
        test_init_collision;
        test_wrap;
        test_reset_mid;
`ifdef PCIE_INGRESS_STATS_EN
        test_stats;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pcie_ingress_ctrl.md
# pcie_ingress_ctrl

Ingress flow controller that sits directly upstream of the PCIe transaction block and drives its `data_in_principal`/`push` input. It accepts 6-bit words from a host-side valid/ready source, buffers them in a small FIFO, and launches them downstream one per cycle unless the main FIFO asserts `Pausa_MF`. It reports idle/active/error status and detects a host that keeps pushing into a full buffer.

## Interface
- `DATA_W`, 6: word width; must match the `data_in_principal` width.
- `DEPTH`, 4: ingress buffer entries; power of two, ≥2.
- `STALL_MAX`, 8: consecutive cycles of `host_valid` while full before an error.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `init`  in  1  synchronous flush/re-initialise request.
- `host_data`  in  DATA_W  word offered by the host.
- `host_valid`  in  1  `host_data` is valid.
- `host_ready`  out  1  block can accept a word this cycle.
- `Pausa_MF`  in  1  downstream main-FIFO almost-full pause.
- `data_in_principal`  out  DATA_W  registered word to the downstream block.
- `push`  out  1  registered strobe qualifying `data_in_principal`.
- `idle_out`  out  1  state is IDLE.
- `active_out`  out  1  state is ACTIVE.
- `error_out`  out  1  state is ERROR (sticky).

## Operation
- States: IDLE, ACTIVE, INIT, ERROR. Reset enters IDLE with the buffer empty.
- The host transfers a word when `host_valid && host_ready` at a clock edge.
- `host_ready = reset_L && (IDLE || ACTIVE) && !full`. It is combinational and never depends on `host_valid`.
- IDLE → ACTIVE when the buffer becomes non-empty.
- ACTIVE → IDLE when the buffer is empty and no transfer occurs that cycle.
- In any state, `init`=1 → INIT next cycle. In INIT, the buffer pointers, count, and stall counter clear, and `push`=0. INIT → IDLE on the first edge with `init`=0.
- Stall counter:
  - Increments each cycle with `host_valid`=1 and buffer full.
  - Clears on any cycle without that condition.
  - Reaching `STALL_MAX` → ERROR.
- In ERROR, `host_ready`=0 and `push`=0, and the buffer contents are held. Only `init` or reset exits ERROR.
- Launch: in ACTIVE with the buffer non-empty and `Pausa_MF`=0 sampled at the edge, pop the head. On that edge, `data_in_principal` ← head and `push` ← 1. Otherwise `push` ← 0 and `data_in_principal` holds its last value.
- A write and a launch in the same cycle are both performed and the count is unchanged. Writes are never accepted when full, even if a launch frees an entry that cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits; full means count==DEPTH, empty means count==0.

## Timing
- Reset values: `push`=0, `data_in_principal`=0, `idle_out`=1, `active_out`=0, `error_out`=0, `host_ready`=0 while `reset_L`=0.
- Latency: a word accepted at edge N into an empty buffer moves IDLE→ACTIVE at N. It launches at edge N+1, so `push`=1 in cycle N+1..N+2.
- Throughput: one word per cycle while `Pausa_MF`=0.
- `Pausa_MF` takes effect at the same edge it is sampled. No word launches on an edge where it is 1.
- `reset_L` falling mid-transfer immediately clears all state and outputs. Buffered words are lost.
- `init` and `host_valid` in the same cycle: INIT wins and the word is not accepted.

## Configuration
- `PCIE_INGRESS_STATS_EN`: when defined, adds the output `words_sent` (16 bits). It counts launched words, wraps at 2^16, and clears on reset or INIT.
- Without the macro, the port and counter do not exist and all other behaviour is identical.

## Structure
- Shared package `pcie_pkg`: state encoding (IDLE=2'd0, ACTIVE=2'd1, INIT=2'd2, ERROR=2'd3) and the `DATA_W` default, reused by the transaction block and its testbench.
- One sub-module, `pcie_ingress_fifo`:
  - DEPTH×DATA_W register file with write/read pointers and count.
  - Outputs full/empty and head.
  - The FSM, launch, and stall logic stay in the top.

## Test plan
- Reset, then host writes 0x15, 0x2A, 0x3F back-to-back with `Pausa_MF`=0 → `push` high for 3 consecutive cycles starting one cycle after the first accept, data 0x15, 0x2A, 0x3F; `idle_out` returns to 1 after the last launch.
- Hold `Pausa_MF`=1 and write 4 words → no `push`; `host_ready`=0 after the 4th. Drop `Pausa_MF` → 4 pushes in order.
- Buffer full with `Pausa_MF`=1 and `host_valid` held 8 cycles → `error_out`=1, `host_ready`=0. Pulse `init` → IDLE, count 0, `error_out`=0.
- Buffer with 2 words, then simultaneous write and launch for 6 cycles with alternating data → count stays 2 and the output order matches the input order across pointer wrap.
- Assert `reset_L`=0 mid-stream → `push`=0, `data_in_principal`=0 immediately; after release the buffer is empty and `idle_out`=1.
- With `PCIE_INGRESS_STATS_EN`, send 5 words → `words_sent`=5; after `init` → 0.
